// File: rtl/matrix_operand_sequencer_if.sv
// ============================================================================
// Module      : matrix_operand_sequencer_if
// Description : Element load stream, engine operand/result and result stream
//               bundle for the matrix operand sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface matrix_operand_sequencer_if #(
   parameter int BITS = 2,
   parameter int SIZE = 4,
   parameter int IDXW = 2,
   parameter int DW   = 2*BITS+SIZE/2
);
   logic                 IN_VALID;
   logic                 IN_READY;
   logic [BITS-1:0]      IN_DATA;
   logic [BITS*SIZE-1:0] ROW_OUT;
   logic [BITS*SIZE-1:0] COL_OUT;
   logic [DW-1:0]        DOT_IN;
   logic                 RES_VALID;
   logic                 RES_READY;
   logic [DW-1:0]        RES_DATA;
   logic [IDXW-1:0]      RES_ROW;
   logic [IDXW-1:0]      RES_COL;
   logic                 RES_LAST;
   logic                 BUSY;

   // Sequencer side
   modport slave (
      input  IN_VALID, IN_DATA, DOT_IN, RES_READY,
      output IN_READY, ROW_OUT, COL_OUT, RES_VALID, RES_DATA,
             RES_ROW, RES_COL, RES_LAST, BUSY
   );

   // Producer / engine / consumer side
   modport master (
      output IN_VALID, IN_DATA, DOT_IN, RES_READY,
      input  IN_READY, ROW_OUT, COL_OUT, RES_VALID, RES_DATA,
             RES_ROW, RES_COL, RES_LAST, BUSY
   );
endinterface

`default_nettype wire

// File: rtl/matrix_operand_sequencer.sv
// ============================================================================
// Module      : matrix_operand_sequencer
// Description : Loads two SIZE x SIZE matrices from an element stream, feeds
//               row/column operand pairs to an external dot-product engine
//               and streams the result matrix out row-major.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_operand_sequencer #(
   parameter int BITS = 2,
   parameter int SIZE = 4,
   parameter int IDXW = 2,
   parameter int DW   = 2*BITS+SIZE/2
) (
   input  logic                        CLK,
   input  logic                        RST,
   matrix_operand_sequencer_if.slave   bus
);

   localparam int              NE       = SIZE*SIZE;
   localparam int              CW       = 2*IDXW;
   localparam logic [CW-1:0]   LAST_CNT = CW'(NE-1);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SIZE-1);

   typedef enum logic [1:0] {
      S_LOAD_A = 2'd0,
      S_LOAD_B = 2'd1,
      S_ISSUE  = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IDXW-1:0]      r_q, r_d;
   logic [IDXW-1:0]      c_q, c_d;
   logic [BITS-1:0]      a_mem_q [NE];
   logic [BITS-1:0]      a_mem_d [NE];
   logic [BITS-1:0]      b_mem_q [NE];
   logic [BITS-1:0]      b_mem_d [NE];
   logic [BITS*SIZE-1:0] row_q, row_d;
   logic [BITS*SIZE-1:0] col_q, col_d;
   logic [DW-1:0]        res_data_q, res_data_d;
   logic [IDXW-1:0]      res_row_q, res_row_d;
   logic [IDXW-1:0]      res_col_q, res_col_d;
   logic                 res_last_q, res_last_d;
   logic                 load_ops;

   // Next-state, storage write and operand selection for the current state
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      r_d        = r_q;
      c_d        = c_q;
      a_mem_d    = a_mem_q;
      b_mem_d    = b_mem_q;
      row_d      = row_q;
      col_d      = col_q;
      res_data_d = res_data_q;
      res_row_d  = res_row_q;
      res_col_d  = res_col_q;
      res_last_d = res_last_q;
      load_ops   = 1'b0;

      case (state_q)
         S_LOAD_A: begin
            if (bus.IN_VALID) begin
               a_mem_d[cnt_q] = bus.IN_DATA;
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  state_d = S_LOAD_B;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_LOAD_B: begin
            if (bus.IN_VALID) begin
               b_mem_d[cnt_q] = bus.IN_DATA;
               if (cnt_q == LAST_CNT) begin
                  cnt_d    = '0;
                  r_d      = '0;
                  c_d      = '0;
                  load_ops = 1'b1;
                  state_d  = S_ISSUE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_ISSUE: begin
            // Operands have settled for a cycle; take the engine result
            res_data_d = bus.DOT_IN;
            res_row_d  = r_q;
            res_col_d  = c_q;
            res_last_d = (r_q == LAST_IDX) && (c_q == LAST_IDX);
            state_d    = S_HOLD;
         end
         S_HOLD: begin
            if (bus.RES_READY) begin
               if (res_last_q) begin
                  cnt_d   = '0;
                  state_d = S_LOAD_A;
               end else begin
                  if (c_q == LAST_IDX) begin
                     c_d = '0;
                     r_d = r_q + 1'b1;
                  end else begin
                     c_d = c_q + 1'b1;
                  end
                  load_ops = 1'b1;
                  state_d  = S_ISSUE;
               end
            end
         end
         default: state_d = S_LOAD_A;
      endcase

      // Read from the post-write arrays so the final B element is visible
      if (load_ops) begin
         for (int j = 0; j < SIZE; j++) begin
            row_d[j*BITS +: BITS] = a_mem_d[{r_d, IDXW'(j)}];
            col_d[j*BITS +: BITS] = b_mem_d[{IDXW'(j), c_d}];
         end
      end
   end

   // Control and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_LOAD_A;
         cnt_q      <= '0;
         r_q        <= '0;
         c_q        <= '0;
         row_q      <= '0;
         col_q      <= '0;
         res_data_q <= '0;
         res_row_q  <= '0;
         res_col_q  <= '0;
         res_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         r_q        <= r_d;
         c_q        <= c_d;
         row_q      <= row_d;
         col_q      <= col_d;
         res_data_q <= res_data_d;
         res_row_q  <= res_row_d;
         res_col_q  <= res_col_d;
         res_last_q <= res_last_d;
      end
   end

   // Matrix storage; contents are meaningless until reloaded after reset
   always_ff @(posedge CLK) begin
      a_mem_q <= a_mem_d;
      b_mem_q <= b_mem_d;
   end

   assign bus.IN_READY  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
   assign bus.RES_VALID = (state_q == S_HOLD);
   assign bus.BUSY      = !((state_q == S_LOAD_A) && (cnt_q == '0));
   assign bus.ROW_OUT   = row_q;
   assign bus.COL_OUT   = col_q;
   assign bus.RES_DATA  = res_data_q;
   assign bus.RES_ROW   = res_row_q;
   assign bus.RES_COL   = res_col_q;
   assign bus.RES_LAST  = res_last_q;

endmodule

`default_nettype wire

// File: doc/matrix_operand_sequencer.md
Name: matrix_operand_sequencer

Overview:
- Front end and back end for the combinational dot-product engine (packed row vector × packed column vector → sum of products).
- Accepts two SIZE×SIZE unsigned matrices A and B as a serial element stream and stores them.
- For every (r,c) it drives row r of A and column c of B onto the engine's packed operand inputs.
- It captures the engine's dot-product result and streams the SIZE×SIZE result matrix out with a valid/ready handshake.

Parameters:
- BITS, 2, width of one unsigned matrix element.
- SIZE, 4, matrix dimension and vector length; power of two, ≥2.
- IDXW, 2, width of row/column indices; must equal log2(SIZE).
- DW, 2*BITS+SIZE/2, dot-product result width; matches the engine output width.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  element on IN_DATA is valid.
- IN_READY  out  1  sequencer accepts an element this cycle.
- IN_DATA  in  BITS  element value, unsigned.
- ROW_OUT  out  BITS*SIZE  packed row r of A to the engine's first operand.
- COL_OUT  out  BITS*SIZE  packed column c of B to the engine's second operand.
- DOT_IN  in  DW  engine result for ROW_OUT·COL_OUT.
- RES_VALID  out  1  RES_DATA/RES_ROW/RES_COL/RES_LAST valid.
- RES_READY  in  1  downstream accepts the result.
- RES_DATA  out  DW  C[r][c].
- RES_ROW  out  IDXW  r of the current result.
- RES_COL  out  IDXW  c of the current result.
- RES_LAST  out  1  high with the (SIZE-1,SIZE-1) result.
- BUSY  out  1  high in any state other than LOAD_A with a zero load count.

Behaviour:

Element transfer and load order
- A transfer occurs when IN_VALID & IN_READY are both high at a rising edge.
- Load order is A row-major (A[0][0], A[0][1], …), then B row-major; 2*SIZE*SIZE transfers in total.

Operand packing
- ROW_OUT bits [j*BITS +: BITS] = A[r][j].
- COL_OUT bits [j*BITS +: BITS] = B[j][c], for j = 0..SIZE-1.
- ROW_OUT and COL_OUT are registered and change only on entry to ISSUE.

States
- LOAD_A:
  - IN_READY=1.
  - Each transfer writes A at the load counter and increments the counter.
  - After transfer SIZE*SIZE-1, the counter clears and the state goes to LOAD_B.
- LOAD_B:
  - IN_READY=1; same as LOAD_A but writes B.
  - After the last transfer, (r,c)=(0,0), operands are loaded and the state goes to ISSUE.
- ISSUE:
  - IN_READY=0, RES_VALID=0; operands are stable for one settle cycle.
  - Next state is HOLD; DOT_IN is registered into RES_DATA at that edge, and RES_ROW/RES_COL/RES_LAST are set.
- HOLD:
  - RES_VALID=1; outputs are held stable while RES_READY=0.
  - On RES_READY=1:
    - If (r,c) ≠ (SIZE-1,SIZE-1): advance c (wrap to 0 and increment r), load the new operands, go to ISSUE.
    - Otherwise: go to LOAD_A with the counter at 0.

Timing
- Last B transfer at cycle t → RES_VALID high at cycle t+2.
- Result handshake at cycle u → next RES_VALID at u+2; RES_VALID is low for exactly one cycle between results.
- Maximum throughput is one result per 2 cycles.

Reset
- Applies at the clock edge and takes priority over all other actions.
- State → LOAD_A; counters, r and c → 0.
- IN_READY=1, RES_VALID=0, RES_DATA=0, RES_ROW=0, RES_COL=0, RES_LAST=0, ROW_OUT=0, COL_OUT=0, BUSY=0.
- Stored matrix contents are don't-care after reset.
- A reset mid-load or mid-drain discards partial data. The next stream restarts at A[0][0].

Other rules
- IN_VALID is ignored outside LOAD_A/LOAD_B. There is no overlap of loading with draining.
- Arithmetic: all unsigned. RES_DATA is DOT_IN verbatim; no extension or truncation in this block. DW is sufficient for SIZE*(2^BITS-1)^2 at the default parameters.
- IN_DATA may change freely while IN_VALID=0.
- RES_READY held high in ISSUE has no effect.

Test Plan:
- Reset then load: A all 3, B all 3 → 16 results, each RES_DATA=36; RES_LAST only on (3,3); results in row-major (r,c) order.
- Load A = identity, B[i][j]=(i+j)%4 → RES_DATA sequence equals B row-major; RES_ROW/RES_COL match each element.
- IN_VALID toggling 1/0 every cycle during load → stored order unaffected; first RES_VALID exactly 2 cycles after the 32nd transfer.
- RES_READY low for 5 cycles on result (1,2) → RES_DATA/RES_ROW/RES_COL/RES_LAST stable throughout; next result appears 2 cycles after the handshake.
- RST asserted after 10 A elements, then a full fresh load with A all 1, B all 2 → all results 8; no stale data.
- RST asserted in HOLD at result (2,0) → the next cycle shows RES_VALID=0, IN_READY=1, BUSY=0; IN_VALID during the reset cycle is not captured.
